// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning HI/LO.
// Results are computed at start and committed after a fixed latency.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [2:0]  i_multctrl,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [1:0]  i_muwe,
    input  logic [1:0]  i_mure,
    output logic        o_busy,
    output logic [31:0] o_rdata,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [7:0] MCYC = 8'(MULT_CYCLES);
    localparam logic [7:0] DCYC = 8'(DIV_CYCLES);

    state_t      r_state;
    state_t      w_state_nx;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nx;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_phi;
    logic [31:0] r_plo;
    logic        r_divz;
    logic        w_load;
    logic        w_commit;
    logic        w_mtwr;

    logic [63:0]        w_sprod;
    logic [63:0]        w_uprod;
    logic [31:0]        w_bd;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic               w_ovf;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;

    // Full 64-bit products and guarded quotient/remainder of the operands.
    always_comb begin
        w_sprod = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
        w_uprod = {32'b0, i_a} * {32'b0, i_b};
        w_bd    = (i_b == 32'd0) ? 32'd1 : i_b;
        w_ovf   = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
        w_sq    = w_ovf ? 32'sh8000_0000 : ($signed(i_a) / $signed(w_bd));
        w_sr    = w_ovf ? 32'sd0 : ($signed(i_a) % $signed(w_bd));
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (i_multctrl)
            3'd0: {w_res_hi, w_res_lo} = w_sprod;
            3'd1: {w_res_hi, w_res_lo} = w_uprod;
            3'd2: begin
                w_res_hi = w_sr;
                w_res_lo = w_sq;
            end
            3'd3: begin
                w_res_hi = i_a % w_bd;
                w_res_lo = i_a / w_bd;
            end
            default: ;
        endcase
    end

    // Next-state, counter and commit decisions.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_load     = 1'b0;
        w_commit   = 1'b0;
        w_mtwr     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start && !i_multctrl[2]) begin
                    w_load     = 1'b1;
                    w_cnt_nx   = i_multctrl[1] ? DCYC : MCYC;
                    w_state_nx = RUN;
                end else if (!i_start) begin
                    w_mtwr = 1'b1;
                end
            end
            RUN: begin
                w_cnt_nx = r_cnt - 8'd1;
                if (r_cnt == 8'd1) begin
                    w_commit   = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // State, counter and pending-result registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_phi   <= 32'd0;
            r_plo   <= 32'd0;
            r_divz  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_load) begin
                r_phi  <= w_res_hi;
                r_plo  <= w_res_lo;
                r_divz <= i_multctrl[1] && (i_b == 32'd0);
            end
        end
    end

    // Architectural HI/LO: commit results or accept mthi/mtlo when idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            if (!r_divz) begin
                r_hi <= r_phi;
                r_lo <= r_plo;
            end
        end else if (w_mtwr) begin
            if (i_muwe == 2'b10) r_hi <= i_a;
            if (i_muwe == 2'b01) r_lo <= i_a;
        end
    end

    // mfhi/mflo read path sees committed values only.
    always_comb begin
        case (i_mure)
            2'b01:   o_rdata = r_lo;
            2'b10:   o_rdata = r_hi;
            default: o_rdata = 32'd0;
        endcase
    end

    assign o_busy = (r_state == RUN);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule
